// File: rtl/id_ex_register.sv
// ============================================================================
// id_ex_register
// ----------------------------------------------------------------------------
// Decode-to-execute pipeline register for the RV32I 5-stage core. It sits
// directly after the register file. It captures the read operands, the
// immediate, the PC, the register indices and the decoded control bundle, and
// presents them to EX one cycle later.
//
// Functions beyond a plain pipeline register:
//   * Write-back bypass. When WB writes the same register that decode is
//     reading in this cycle, WbData is captured instead of the stale
//     register-file value. Register x0 is never bypassed.
//   * Load-use hazard detection. HazardStall is combinational: a valid load
//     in EX whose rd is read by the valid instruction in ID. It causes a
//     bubble to be inserted on the next edge.
//   * Stall. The whole register holds. While it holds, operands that WB
//     writes are refreshed so that a long hold cannot leave a stale value.
//   * Flush. Squashes the instruction entering EX. Flush takes priority over
//     Stall.
//
// Per-edge priority: Flush > Stall > HazardStall bubble > normal load.
//
// Ports:
//   CLK, ResetN              clock (rising edge), async active-low reset
//   IdValid .. IdCtrl        decode-stage instruction fields and RF read data
//   WbRegWrite/WbAddr/WbData write-back port, used for the bypass and refresh
//   Flush, Stall             pipeline control
//   HazardStall              load-use detected; IF/ID must hold this cycle
//   ExValid .. ExCtrl        registered outputs to the execute stage
//
// Optional build macro ID_EX_PERF_CNT_EN adds two saturating performance
// counters, BubbleCount and FlushCount, each REG_WIDTH wide.
// ============================================================================
module id_ex_register #(
    parameter int REG_WIDTH          = 32,
    parameter int ADDRESS_PORT_WIDTH = 5,
    parameter int CTRL_WIDTH         = 16
) (
    input  logic                          CLK,
    input  logic                          ResetN,

    input  logic                          IdValid,
    input  logic [ADDRESS_PORT_WIDTH-1:0] IdRs1,
    input  logic [ADDRESS_PORT_WIDTH-1:0] IdRs2,
    input  logic [ADDRESS_PORT_WIDTH-1:0] IdRd,
    input  logic                          IdUsesRs1,
    input  logic                          IdUsesRs2,
    input  logic                          IdMemRead,
    input  logic [REG_WIDTH-1:0]          ReadData1,
    input  logic [REG_WIDTH-1:0]          ReadData2,
    input  logic [REG_WIDTH-1:0]          IdImm,
    input  logic [REG_WIDTH-1:0]          IdPC,
    input  logic [CTRL_WIDTH-1:0]         IdCtrl,

    input  logic                          WbRegWrite,
    input  logic [ADDRESS_PORT_WIDTH-1:0] WbAddr,
    input  logic [REG_WIDTH-1:0]          WbData,

    input  logic                          Flush,
    input  logic                          Stall,

    output logic                          HazardStall,
`ifdef ID_EX_PERF_CNT_EN
    output logic [REG_WIDTH-1:0]          BubbleCount,
    output logic [REG_WIDTH-1:0]          FlushCount,
`endif
    output logic                          ExValid,
    output logic [ADDRESS_PORT_WIDTH-1:0] ExRs1,
    output logic [ADDRESS_PORT_WIDTH-1:0] ExRs2,
    output logic [ADDRESS_PORT_WIDTH-1:0] ExRd,
    output logic                          ExMemRead,
    output logic [REG_WIDTH-1:0]          ExRs1Data,
    output logic [REG_WIDTH-1:0]          ExRs2Data,
    output logic [REG_WIDTH-1:0]          ExImm,
    output logic [REG_WIDTH-1:0]          ExPC,
    output logic [CTRL_WIDTH-1:0]         ExCtrl
);

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic                          ex_valid_q,    ex_valid_d;
    logic [ADDRESS_PORT_WIDTH-1:0] ex_rs1_q,      ex_rs1_d;
    logic [ADDRESS_PORT_WIDTH-1:0] ex_rs2_q,      ex_rs2_d;
    logic [ADDRESS_PORT_WIDTH-1:0] ex_rd_q,       ex_rd_d;
    logic                          ex_mem_read_q, ex_mem_read_d;
    logic [REG_WIDTH-1:0]          ex_rs1_data_q, ex_rs1_data_d;
    logic [REG_WIDTH-1:0]          ex_rs2_data_q, ex_rs2_data_d;
    logic [REG_WIDTH-1:0]          ex_imm_q,      ex_imm_d;
    logic [REG_WIDTH-1:0]          ex_pc_q,       ex_pc_d;
    logic [CTRL_WIDTH-1:0]         ex_ctrl_q,     ex_ctrl_d;

    logic                          hazard_stall;
    logic                          wb_active;
    logic [REG_WIDTH-1:0]          rs1_fwd;
    logic [REG_WIDTH-1:0]          rs2_fwd;
    logic                          refresh_rs1;
    logic                          refresh_rs2;

    // ------------------------------------------------------------------
    // Write-back bypass for decode-stage reads, and refresh of held operands
    // ------------------------------------------------------------------
    always_comb begin
        wb_active   = WbRegWrite && (WbAddr != '0);
        rs1_fwd     = (wb_active && (WbAddr == IdRs1)) ? WbData : ReadData1;
        rs2_fwd     = (wb_active && (WbAddr == IdRs2)) ? WbData : ReadData2;
        refresh_rs1 = ex_valid_q && wb_active && (WbAddr == ex_rs1_q);
        refresh_rs2 = ex_valid_q && wb_active && (WbAddr == ex_rs2_q);
    end

    // ------------------------------------------------------------------
    // Load-use hazard detection
    // ------------------------------------------------------------------
    always_comb begin
        hazard_stall = ex_valid_q && ex_mem_read_q && (ex_rd_q != '0) && IdValid &&
                       ((IdUsesRs1 && (IdRs1 == ex_rd_q)) ||
                        (IdUsesRs2 && (IdRs2 == ex_rd_q)));
    end

    // ------------------------------------------------------------------
    // Next-state selection
    // ------------------------------------------------------------------
    // Flush, bubble and normal load share one load path. Flush and bubble
    // differ only in clearing the four fields that make the slot inert;
    // the operand fields they leave behind are don't-care.
    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        ex_rd_d       = ex_rd_q;
        ex_mem_read_d = ex_mem_read_q;
        ex_rs1_data_d = ex_rs1_data_q;
        ex_rs2_data_d = ex_rs2_data_q;
        ex_imm_d      = ex_imm_q;
        ex_pc_d       = ex_pc_q;
        ex_ctrl_d     = ex_ctrl_q;

        if (Flush || !Stall) begin
            ex_valid_d    = IdValid;
            ex_rs1_d      = IdRs1;
            ex_rs2_d      = IdRs2;
            ex_rd_d       = IdRd;
            // Gate with IdValid so that an empty slot can never look like a load.
            ex_mem_read_d = IdMemRead && IdValid;
            ex_rs1_data_d = rs1_fwd;
            ex_rs2_data_d = rs2_fwd;
            ex_imm_d      = IdImm;
            ex_pc_d       = IdPC;
            ex_ctrl_d     = IdCtrl;

            if (Flush || hazard_stall) begin
                ex_valid_d    = 1'b0;
                ex_ctrl_d     = '0;
                ex_mem_read_d = 1'b0;
                ex_rd_d       = '0;
            end
        end else begin
            if (refresh_rs1) ex_rs1_data_d = WbData;
            if (refresh_rs2) ex_rs2_data_d = WbData;
        end
    end

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            ex_valid_q    <= 1'b0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_mem_read_q <= 1'b0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_pc_q       <= '0;
            ex_ctrl_q     <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_rd_q       <= ex_rd_d;
            ex_mem_read_q <= ex_mem_read_d;
            ex_rs1_data_q <= ex_rs1_data_d;
            ex_rs2_data_q <= ex_rs2_data_d;
            ex_imm_q      <= ex_imm_d;
            ex_pc_q       <= ex_pc_d;
            ex_ctrl_q     <= ex_ctrl_d;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [REG_WIDTH-1:0] bubble_count_q, bubble_count_d;
    logic [REG_WIDTH-1:0] flush_count_q,  flush_count_d;

    always_comb begin
        bubble_count_d = bubble_count_q;
        flush_count_d  = flush_count_q;
        // A bubble counts only when it is actually inserted, which means
        // Flush and Stall do not win this edge.
        if (!Flush && !Stall && hazard_stall && (bubble_count_q != '1))
            bubble_count_d = bubble_count_q + 1'b1;
        if (Flush && (flush_count_q != '1))
            flush_count_d = flush_count_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            bubble_count_q <= '0;
            flush_count_q  <= '0;
        end else begin
            bubble_count_q <= bubble_count_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign BubbleCount = bubble_count_q;
    assign FlushCount  = flush_count_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign HazardStall = hazard_stall;
    assign ExValid     = ex_valid_q;
    assign ExRs1       = ex_rs1_q;
    assign ExRs2       = ex_rs2_q;
    assign ExRd        = ex_rd_q;
    assign ExMemRead   = ex_mem_read_q;
    assign ExRs1Data   = ex_rs1_data_q;
    assign ExRs2Data   = ex_rs2_data_q;
    assign ExImm       = ex_imm_q;
    assign ExPC        = ex_pc_q;
    assign ExCtrl      = ex_ctrl_q;

endmodule
